// File: rtl/escaner_canales.sv
// escaner_canales
//   Scans the four inputs of an external 4:1 multiplexer. Each scan visits
//   channels 0..3 in order. For each channel it drives o_Sel, waits
//   ASENTAMIENTO cycles for the mux output to settle, and then captures
//   i_Dato into that channel's result register.
//
//   Optional feature, selected by the macro ESCANER_CONTINUO_EN:
//     undefined -> one scan per i_Inicio request, then back to idle.
//     defined   -> after the first request, scans repeat back-to-back
//                  until reset.
//
// Ports
//   i_Clk               clock; all state changes on its rising edge
//   i_Rst               synchronous, active-high reset
//   i_Inicio            start request; honoured only while idle
//   i_Dato[ANCHO]       mux output for the channel currently on o_Sel
//   o_Sel[2]            channel select driven to the mux
//   o_Ocupado           high while a scan is in progress
//   o_Listo             one-cycle pulse when a 4-channel scan completes
//   o_Canal_0..3[ANCHO] last captured value of each channel
module escaner_canales #(
  parameter int ANCHO        = 4,
  parameter int ASENTAMIENTO = 3
) (
  input  logic             i_Clk,
  input  logic             i_Rst,
  input  logic             i_Inicio,
  input  logic [ANCHO-1:0] i_Dato,
  output logic [1:0]       o_Sel,
  output logic             o_Ocupado,
  output logic             o_Listo,
  output logic [ANCHO-1:0] o_Canal_0,
  output logic [ANCHO-1:0] o_Canal_1,
  output logic [ANCHO-1:0] o_Canal_2,
  output logic [ANCHO-1:0] o_Canal_3
);

  typedef enum logic [1:0] {
    REPOSO  = 2'd0,
    ASENTAR = 2'd1,
    CAPTURA = 2'd2,
    FIN     = 2'd3
  } estado_t;

  // Settle count at which ASENTAR hands over to CAPTURA. ASENTAR
  // therefore lasts exactly ASENTAMIENTO cycles.
  localparam logic [7:0] CNT_ULTIMO = 8'(ASENTAMIENTO - 1);

  estado_t          estado_q, estado_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic [1:0]       sel_q, sel_d;
  logic             ocupado_q, ocupado_d;
  logic             listo_q, listo_d;
  logic [ANCHO-1:0] canal_q [4];
  logic [ANCHO-1:0] canal_d [4];

  always_comb begin
    estado_d  = estado_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    sel_d     = sel_q;
    ocupado_d = ocupado_q;
    listo_d   = 1'b0;
    canal_d   = canal_q;

    case (estado_q)
      REPOSO: begin
        sel_d     = 2'd0;
        ocupado_d = 1'b0;
        if (i_Inicio) begin
          estado_d  = ASENTAR;
          idx_d     = 2'd0;
          cnt_d     = 8'd0;
          ocupado_d = 1'b1;
        end
      end

      ASENTAR: begin
        cnt_d = cnt_q + 8'd1;
        if (cnt_q == CNT_ULTIMO) begin
          estado_d = CAPTURA;
        end
      end

      CAPTURA: begin
        // o_Sel is left alone here. It only moves after the capture edge,
        // so the mux has been stable for the whole settle window.
        canal_d[idx_q] = i_Dato;
        if (idx_q != 2'd3) begin
          idx_d    = idx_q + 2'd1;
          sel_d    = idx_q + 2'd1;
          cnt_d    = 8'd0;
          estado_d = ASENTAR;
        end else begin
          estado_d = FIN;
          listo_d  = 1'b1;
        end
      end

      FIN: begin
`ifdef ESCANER_CONTINUO_EN
        estado_d  = ASENTAR;
        idx_d     = 2'd0;
        cnt_d     = 8'd0;
        sel_d     = 2'd0;
        ocupado_d = 1'b1;
`else
        estado_d  = REPOSO;
        sel_d     = 2'd0;
        ocupado_d = 1'b0;
`endif
      end

      default: begin
        estado_d = REPOSO;
      end
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      estado_q  <= REPOSO;
      cnt_q     <= 8'd0;
      idx_q     <= 2'd0;
      sel_q     <= 2'd0;
      ocupado_q <= 1'b0;
      listo_q   <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        canal_q[i] <= '0;
      end
    end else begin
      estado_q  <= estado_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      sel_q     <= sel_d;
      ocupado_q <= ocupado_d;
      listo_q   <= listo_d;
      canal_q   <= canal_d;
    end
  end

  assign o_Sel     = sel_q;
  assign o_Ocupado = ocupado_q;
  assign o_Listo   = listo_q;
  assign o_Canal_0 = canal_q[0];
  assign o_Canal_1 = canal_q[1];
  assign o_Canal_2 = canal_q[2];
  assign o_Canal_3 = canal_q[3];

endmodule

// File: tb/tb_escaner_canales.sv
// Testbench for escaner_canales.
//   dut : default parameters (ASENTAMIENTO=3)
//   dut1: ASENTAMIENTO=1
// Each instance has its own behavioural 4:1 mux model feeding i_Dato.
// Define ESCANER_CONTINUO_EN to build and check the continuous-scan variant.
module tb_escaner_canales;

  logic       clk = 1'b0;
  logic       rst, inicio;
  logic [1:0] sel;
  logic       ocup, listo;
  logic [3:0] dato, c0, c1, c2, c3;
  logic [3:0] mux [4];

  logic       rst1, inicio1;
  logic [1:0] sel1;
  logic       ocup1, listo1;
  logic [3:0] dato1, d1c0, d1c1, d1c2, d1c3;
  logic [3:0] mux1 [4];

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  assign dato  = mux[sel];
  assign dato1 = mux1[sel1];

  escaner_canales dut (
    .i_Clk(clk), .i_Rst(rst), .i_Inicio(inicio), .i_Dato(dato),
    .o_Sel(sel), .o_Ocupado(ocup), .o_Listo(listo),
    .o_Canal_0(c0), .o_Canal_1(c1), .o_Canal_2(c2), .o_Canal_3(c3)
  );

  escaner_canales #(.ANCHO(4), .ASENTAMIENTO(1)) dut1 (
    .i_Clk(clk), .i_Rst(rst1), .i_Inicio(inicio1), .i_Dato(dato1),
    .o_Sel(sel1), .o_Ocupado(ocup1), .o_Listo(listo1),
    .o_Canal_0(d1c0), .o_Canal_1(d1c1), .o_Canal_2(d1c2), .o_Canal_3(d1c3)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; rst1 = 1'b1; inicio = 1'b0; inicio1 = 1'b0;
    step();
    step();
    rst = 1'b0; rst1 = 1'b0;
    n_chk++;
    if ({sel, ocup, listo} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_ctrl got %b want 0000", {sel, ocup, listo});
    end
    n_chk++;
    if ({c3, c2, c1, c0} !== 16'h0000) begin
      n_fail++; $display("FAIL reset_canales got %h want 0000", {c3, c2, c1, c0});
    end
    n_chk++;
    if ({sel1, ocup1, listo1, d1c3, d1c2, d1c1, d1c0} !== 20'h0) begin
      n_fail++; $display("FAIL reset_dut1 got %h want 0",
                         {sel1, ocup1, listo1, d1c3, d1c2, d1c1, d1c0});
    end
  endtask

`ifndef ESCANER_CONTINUO_EN
  task automatic test_basic();
    logic [1:0] es;
    logic       eo, el;
    mux[0] = 4'h1; mux[1] = 4'h2; mux[2] = 4'h3; mux[3] = 4'h4;
    inicio = 1'b1;
    step();
    inicio = 1'b0;
    for (int c = 1; c <= 18; c++) begin
      if (c > 1) step();
      if (c <= 16) begin
        es = 2'((c - 1) / 4); eo = 1'b1; el = 1'b0;
      end else if (c == 17) begin
        es = 2'd3; eo = 1'b1; el = 1'b1;
      end else begin
        es = 2'd0; eo = 1'b0; el = 1'b0;
      end
      n_chk++;
      if ({sel, ocup, listo} !== {es, eo, el}) begin
        n_fail++;
        $display("FAIL basic_c%0d sel/ocup/listo got %b want %b", c,
                 {sel, ocup, listo}, {es, eo, el});
      end
      if (c == 9) begin
        n_chk++;
        if ({c3, c2, c1, c0} !== 16'h0021) begin
          n_fail++; $display("FAIL basic_parcial got %h want 0021", {c3, c2, c1, c0});
        end
      end
    end
    n_chk++;
    if ({c3, c2, c1, c0} !== 16'h4321) begin
      n_fail++; $display("FAIL basic_canales got %h want 4321", {c3, c2, c1, c0});
    end
  endtask

  task automatic test_settle_change();
    mux[0] = 4'h5; mux[1] = 4'h6; mux[2] = 4'hA; mux[3] = 4'h7;
    inicio = 1'b1;
    step();
    inicio = 1'b0;
    for (int c = 2; c <= 18; c++) begin
      step();
      if (c == 10) mux[2] = 4'hB;
      if (c == 12) begin
        n_chk++;
        if (c2 !== 4'h3) begin
          n_fail++; $display("FAIL settle_antes got %h want 3", c2);
        end
      end
      if (c == 13) begin
        n_chk++;
        if (c2 !== 4'hB) begin
          n_fail++; $display("FAIL settle_captura got %h want b", c2);
        end
      end
    end
    n_chk++;
    if ({ocup, c3, c2, c1, c0} !== 17'h07B65) begin
      n_fail++; $display("FAIL settle_final got %h want 07b65", {ocup, c3, c2, c1, c0});
    end
  endtask

  task automatic test_inicio_held();
    int n_listo;
    int primero;
    n_listo = 0; primero = 0;
    mux[0] = 4'h8; mux[1] = 4'h9; mux[2] = 4'hC; mux[3] = 4'hD;
    inicio = 1'b1;
    step();
    for (int c = 2; c <= 19; c++) begin
      step();
      if (listo === 1'b1) begin
        n_listo++;
        if (primero == 0) primero = c;
      end
      if (c == 18) begin
        n_chk++;
        if (ocup !== 1'b0) begin
          n_fail++; $display("FAIL held_reposo ocup got %b want 0", ocup);
        end
      end
      if (c == 19) begin
        n_chk++;
        if ({ocup, sel} !== 3'b100) begin
          n_fail++; $display("FAIL held_rearranque got %b want 100", {ocup, sel});
        end
      end
    end
    inicio = 1'b0;
    n_chk++;
    if (n_listo != 1 || primero != 17) begin
      n_fail++; $display("FAIL held_listo got n=%0d at %0d want n=1 at 17", n_listo, primero);
    end
  endtask

  task automatic test_reset_mid();
    int n_act;
    n_act = 0;
    // Second scan started at c=19; step to its channel-1 settle window.
    for (int c = 20; c <= 24; c++) step();
    n_chk++;
    if ({ocup, sel} !== 3'b101) begin
      n_fail++; $display("FAIL mid_canal1 got %b want 101", {ocup, sel});
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_chk++;
    if ({sel, ocup, listo, c3, c2, c1, c0} !== 20'h0) begin
      n_fail++; $display("FAIL mid_reset got %h want 0", {sel, ocup, listo, c3, c2, c1, c0});
    end
    for (int c = 0; c < 20; c++) begin
      step();
      if (listo !== 1'b0 || ocup !== 1'b0) n_act++;
    end
    n_chk++;
    if (n_act != 0) begin
      n_fail++; $display("FAIL mid_abort active cycles got %0d want 0", n_act);
    end
    rst = 1'b1; inicio = 1'b1;
    step();
    n_chk++;
    if ({ocup, sel, listo} !== 4'b0000) begin
      n_fail++; $display("FAIL rst_gana got %b want 0000", {ocup, sel, listo});
    end
    rst = 1'b0; inicio = 1'b0;
    step();
    n_chk++;
    if (ocup !== 1'b0) begin
      n_fail++; $display("FAIL rst_gana_despues ocup got %b want 0", ocup);
    end
  endtask
`else
  task automatic test_continuo();
    int         p;
    logic [1:0] es;
    logic       el;
    mux[0] = 4'h1; mux[1] = 4'h2; mux[2] = 4'h3; mux[3] = 4'h4;
    inicio = 1'b1;
    step();
    inicio = 1'b0;
    for (int c = 1; c <= 52; c++) begin
      if (c > 1) step();
      p  = (c - 1) % 17;
      es = (p < 16) ? 2'(p / 4) : 2'd3;
      el = (p == 16);
      n_chk++;
      if ({sel, ocup, listo} !== {es, 1'b1, el}) begin
        n_fail++;
        $display("FAIL continuo_c%0d got %b want %b", c, {sel, ocup, listo}, {es, 1'b1, el});
      end
    end
    n_chk++;
    if ({c3, c2, c1, c0} !== 16'h4321) begin
      n_fail++; $display("FAIL continuo_canales got %h want 4321", {c3, c2, c1, c0});
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    n_chk++;
    if ({ocup, listo} !== 2'b00) begin
      n_fail++; $display("FAIL continuo_reset got %b want 00", {ocup, listo});
    end
  endtask
`endif

  task automatic test_asentamiento_1();
    logic [1:0] es;
    logic       el;
    mux1[0] = 4'hE; mux1[1] = 4'h3; mux1[2] = 4'h7; mux1[3] = 4'h1;
    inicio1 = 1'b1;
    step();
    inicio1 = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      if (c > 1) step();
      if (c <= 9) begin
        es = (c <= 8) ? 2'((c - 1) / 2) : 2'd3;
        el = (c == 9);
        n_chk++;
        if ({sel1, ocup1, listo1} !== {es, 1'b1, el}) begin
          n_fail++;
          $display("FAIL asent1_c%0d got %b want %b", c, {sel1, ocup1, listo1}, {es, 1'b1, el});
        end
      end
`ifndef ESCANER_CONTINUO_EN
      if (c == 10) begin
        n_chk++;
        if ({ocup1, listo1} !== 2'b00) begin
          n_fail++; $display("FAIL asent1_fin got %b want 00", {ocup1, listo1});
        end
      end
`endif
    end
    n_chk++;
    if ({d1c3, d1c2, d1c1, d1c0} !== 16'h173E) begin
      n_fail++; $display("FAIL asent1_canales got %h want 173e", {d1c3, d1c2, d1c1, d1c0});
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      mux[i]  = 4'h0;
      mux1[i] = 4'h0;
    end
    test_reset();
`ifndef ESCANER_CONTINUO_EN
    test_basic();
    test_settle_change();
    test_inicio_held();
    test_reset_mid();
`else
    test_continuo();
`endif
    test_asentamiento_1();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
